// File: rtl/rx_frame_assembler.sv
// rx_frame_assembler: collects five-byte instruction frames (op, a1, a2, b1, b2)
// from a byte stream. Frames with an illegal opcode are dropped, and partial
// frames that stall are discarded. Complete frames go to decode over
// valid/ready. One extra frame can wait in the assembly registers while the
// output slot is still occupied.
module rx_frame_assembler #(
   parameter logic [7:0] MAX_OP      = 8'h0F,
   parameter int         TIMEOUT_CYC = 1024,
   parameter int         CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             alu_ready,
   output logic             rx_valid,
   output logic [7:0]       op,
   output logic [7:0]       a1,
   output logic [7:0]       a2,
   output logic [7:0]       b1,
   output logic [7:0]       b2,
   output logic             err_op,
   output logic             err_timeout,
   output logic [CNT_W-1:0] frames_out
);

   localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   // The timer value seen on the last idle cycle before the limit is reached
   localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYC > 0) ? TMR_W'(TIMEOUT_CYC - 1) : '0;

   typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

   state_t           state;
   logic [2:0]       idx;
   logic             bad;
   logic [TMR_W-1:0] timer;
   logic [7:0]       f_op, f_a1, f_a2, f_b1, f_b2;
   logic             accept, xfer, slot_free;

   // in_ready depends on state alone so that upstream never sees a combinational path from valid/ready
   assign in_ready  = (state != FULL);
   assign accept    = in_valid && in_ready;
   assign xfer      = rx_valid && alu_ready;
   assign slot_free = !rx_valid || alu_ready;

   // Frame assembly FSM, output slot, error pulses and delivered-frame counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         bad         <= 1'b0;
         timer       <= '0;
         f_op        <= '0;
         f_a1        <= '0;
         f_a2        <= '0;
         f_b1        <= '0;
         f_b2        <= '0;
         rx_valid    <= 1'b0;
         op          <= '0;
         a1          <= '0;
         a2          <= '0;
         b1          <= '0;
         b2          <= '0;
         err_op      <= 1'b0;
         err_timeout <= 1'b0;
         frames_out  <= '0;
      end else begin
         err_op      <= 1'b0;
         err_timeout <= 1'b0;
         // A transfer empties the slot unless a new frame loads below in the same cycle
         if (xfer) begin
            frames_out <= frames_out + 1'b1;
            rx_valid   <= 1'b0;
         end
         case (state)
            IDLE: begin
               idx   <= '0;
               timer <= '0;
               if (accept) begin
                  f_op  <= in_data;
                  bad   <= (in_data > MAX_OP);
                  idx   <= 3'd1;
                  state <= COLLECT;
               end
            end
            COLLECT: begin
               if (accept) begin
                  timer <= '0;
                  idx   <= idx + 3'd1;
                  case (idx)
                     3'd1:    f_a1 <= in_data;
                     3'd2:    f_a2 <= in_data;
                     3'd3:    f_b1 <= in_data;
                     default: f_b2 <= in_data;
                  endcase
                  if (idx == 3'd4) begin
                     idx <= '0;
                     if (bad) begin
                        // Illegal opcode: frame consumed, output slot left alone
                        err_op <= 1'b1;
                        state  <= IDLE;
                     end else if (slot_free) begin
                        // Slot is free or frees this cycle: bypass straight to outputs
                        op       <= f_op;
                        a1       <= f_a1;
                        a2       <= f_a2;
                        b1       <= f_b1;
                        b2       <= in_data;
                        rx_valid <= 1'b1;
                        state    <= IDLE;
                     end else begin
                        state <= FULL;
                     end
                  end
               end else if ((TIMEOUT_CYC != 0) && (timer == TMR_LAST)) begin
                  err_timeout <= 1'b1;
                  idx         <= '0;
                  timer       <= '0;
                  state       <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            FULL: begin
               // rx_valid is known high here, so alu_ready alone means a transfer
               if (alu_ready) begin
                  op       <= f_op;
                  a1       <= f_a1;
                  a2       <= f_a2;
                  b1       <= f_b1;
                  b2       <= f_b2;
                  rx_valid <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Testbench for rx_frame_assembler: table-driven per-cycle vectors plus
// hand-written sequences for timeout, reset and counter wrap.
module tb_rx_frame_assembler;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       alu_ready;
   logic       rx_valid;
   logic [7:0] op, a1, a2, b1, b2;
   logic       err_op, err_timeout;
   logic [3:0] frames_out;

   int n_chk = 0;
   int n_err = 0;

   rx_frame_assembler #(
      .MAX_OP      (8'h0F),
      .TIMEOUT_CYC (8),
      .CNT_W       (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_ready   (alu_ready),
      .rx_valid    (rx_valid),
      .op          (op),
      .a1          (a1),
      .a2          (a2),
      .b1          (b1),
      .b2          (b2),
      .err_op      (err_op),
      .err_timeout (err_timeout),
      .frames_out  (frames_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] din;
      logic       vld;
      logic       ardy;
      logic       rxv;
      logic [7:0] op;
      logic [7:0] a1;
      logic [7:0] b2;
      logic       rdy;
      logic [3:0] cnt;
      logic       eop;
      logic       eto;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic [7:0] din, input logic vld, input logic ardy,
                               input logic rxv, input logic [7:0] eop_code, input logic [7:0] ea1,
                               input logic [7:0] eb2, input logic rdy, input logic [3:0] cnt,
                               input logic eop, input logic eto);
      vec_t v;
      v.din = din; v.vld = vld; v.ardy = ardy; v.rxv = rxv; v.op = eop_code;
      v.a1 = ea1; v.b2 = eb2; v.rdy = rdy; v.cnt = cnt; v.eop = eop; v.eto = eto;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic a);
      in_data   = d;
      in_valid  = 1'b1;
      alu_ready = a;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic idle(input logic a);
      in_valid  = 1'b0;
      alu_ready = a;
      tick();
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " rx_valid"}, 32'(rx_valid), 32'd0);
      chk({tag, " op"}, 32'(op), 32'd0);
      chk({tag, " a1"}, 32'(a1), 32'd0);
      chk({tag, " a2"}, 32'(a2), 32'd0);
      chk({tag, " b1"}, 32'(b1), 32'd0);
      chk({tag, " b2"}, 32'(b2), 32'd0);
      chk({tag, " err_op"}, 32'(err_op), 32'd0);
      chk({tag, " err_timeout"}, 32'(err_timeout), 32'd0);
      chk({tag, " frames_out"}, 32'(frames_out), 32'd0);
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int eto_seen;

      rst = 1'b1; in_data = '0; in_valid = 1'b0; alu_ready = 1'b0;

      // Basic frame, slot free
      tv.push_back(mk(8'h05, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0));
      tv.push_back(mk(8'h03, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0));
      tv.push_back(mk(8'h04, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0));
      tv.push_back(mk(8'h07, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0));
      tv.push_back(mk(8'h02, 1, 1, 1, 8'h05, 8'h03, 8'h02, 1, 0, 0, 0));
      tv.push_back(mk(8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0));
      // Backpressure: first frame held, second frame waits in FULL
      tv.push_back(mk(8'h01, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0));
      tv.push_back(mk(8'h11, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0));
      tv.push_back(mk(8'h12, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0));
      tv.push_back(mk(8'h13, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0));
      tv.push_back(mk(8'h14, 1, 0, 1, 8'h01, 8'h11, 8'h14, 1, 1, 0, 0));
      tv.push_back(mk(8'h0D, 1, 0, 1, 8'h01, 8'h11, 8'h14, 1, 1, 0, 0));
      tv.push_back(mk(8'h21, 1, 0, 1, 8'h01, 8'h11, 8'h14, 1, 1, 0, 0));
      tv.push_back(mk(8'h22, 1, 0, 1, 8'h01, 8'h11, 8'h14, 1, 1, 0, 0));
      tv.push_back(mk(8'h23, 1, 0, 1, 8'h01, 8'h11, 8'h14, 1, 1, 0, 0));
      tv.push_back(mk(8'h24, 1, 0, 1, 8'h01, 8'h11, 8'h14, 0, 1, 0, 0));
      tv.push_back(mk(8'h55, 1, 0, 1, 8'h01, 8'h11, 8'h14, 0, 1, 0, 0));
      tv.push_back(mk(8'h00, 0, 1, 1, 8'h0D, 8'h21, 8'h24, 1, 2, 0, 0));
      tv.push_back(mk(8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 3, 0, 0));
      // Illegal opcode dropped, then noop frame delivered
      tv.push_back(mk(8'h10, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 3, 0, 0));
      tv.push_back(mk(8'hAA, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 3, 0, 0));
      tv.push_back(mk(8'hBB, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 3, 0, 0));
      tv.push_back(mk(8'hCC, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 3, 0, 0));
      tv.push_back(mk(8'hDD, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 3, 1, 0));
      tv.push_back(mk(8'h00, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 3, 0, 0));
      tv.push_back(mk(8'h01, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 3, 0, 0));
      tv.push_back(mk(8'h02, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 3, 0, 0));
      tv.push_back(mk(8'h03, 1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 3, 0, 0));
      tv.push_back(mk(8'h04, 1, 1, 1, 8'h00, 8'h01, 8'h04, 1, 3, 0, 0));
      tv.push_back(mk(8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 4, 0, 0));

      // Reset state
      tick();
      tick();
      chk_reset_state("reset");
      rst = 1'b0;

      // Table-driven per-cycle vectors
      for (int i = 0; i < tv.size(); i++) begin
         in_data   = tv[i].din;
         in_valid  = tv[i].vld;
         alu_ready = tv[i].ardy;
         tick();
         chk($sformatf("v%0d rx_valid", i), 32'(rx_valid), 32'(tv[i].rxv));
         chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tv[i].rdy));
         chk($sformatf("v%0d frames_out", i), 32'(frames_out), 32'(tv[i].cnt));
         chk($sformatf("v%0d err_op", i), 32'(err_op), 32'(tv[i].eop));
         chk($sformatf("v%0d err_timeout", i), 32'(err_timeout), 32'(tv[i].eto));
         if (tv[i].rxv) begin
            chk($sformatf("v%0d op", i), 32'(op), 32'(tv[i].op));
            chk($sformatf("v%0d a1", i), 32'(a1), 32'(tv[i].a1));
            chk($sformatf("v%0d b2", i), 32'(b2), 32'(tv[i].b2));
         end
      end
      in_valid = 1'b0;

      // Timeout: 3 bytes then 8 idle cycles
      send(8'h07, 1); send(8'h01, 1); send(8'h02, 1);
      eto_seen = 0;
      for (int k = 0; k < 7; k++) begin
         idle(1);
         if (err_timeout) eto_seen++;
      end
      chk("timeout early", 32'(eto_seen), 32'd0);
      idle(1);
      chk("timeout pulse", 32'(err_timeout), 32'd1);
      chk("timeout no err_op", 32'(err_op), 32'd0);
      chk("timeout rx_valid", 32'(rx_valid), 32'd0);
      idle(1);
      chk("timeout pulse width", 32'(err_timeout), 32'd0);
      send(8'h07, 1); send(8'h05, 1); send(8'h06, 1); send(8'h07, 1); send(8'h08, 1);
      chk("post-timeout rx_valid", 32'(rx_valid), 32'd1);
      chk("post-timeout op", 32'(op), 32'h07);
      chk("post-timeout a1", 32'(a1), 32'h05);
      chk("post-timeout a2", 32'(a2), 32'h06);
      chk("post-timeout b1", 32'(b1), 32'h07);
      chk("post-timeout b2", 32'(b2), 32'h08);
      idle(1);
      chk("post-timeout frames_out", 32'(frames_out), 32'd5);

      // Reset mid-frame
      send(8'h02, 1); send(8'h09, 1); send(8'h09, 1);
      do_reset();
      chk_reset_state("rst midframe");
      rst = 1'b0;

      // Reset while a frame is held in FULL
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h05, 0);
      send(8'h06, 0); send(8'h07, 0); send(8'h08, 0); send(8'h09, 0); send(8'h0A, 0);
      chk("full in_ready", 32'(in_ready), 32'd0);
      chk("full rx_valid", 32'(rx_valid), 32'd1);
      do_reset();
      chk_reset_state("rst full");
      rst = 1'b0;
      idle(1);
      chk("rst no stale frame", 32'(rx_valid), 32'd0);
      send(8'h03, 1); send(8'h0A, 1); send(8'h0B, 1); send(8'h0C, 1); send(8'h0E, 1);
      chk("after rst rx_valid", 32'(rx_valid), 32'd1);
      chk("after rst op", 32'(op), 32'h03);
      chk("after rst a1", 32'(a1), 32'h0A);
      chk("after rst b1", 32'(b1), 32'h0C);
      chk("after rst b2", 32'(b2), 32'h0E);
      idle(1);
      chk("after rst frames_out", 32'(frames_out), 32'd1);

      // Counter wrap: 17 back-to-back frames on a 4-bit counter
      do_reset();
      rst = 1'b0;
      for (int f = 0; f < 17; f++) begin
         send(8'(f % 16), 1);
         send(8'h01, 1); send(8'h02, 1); send(8'h03, 1); send(8'h04, 1);
      end
      chk("wrap last op", 32'(op), 32'h00);
      chk("wrap rx_valid", 32'(rx_valid), 32'd1);
      idle(1);
      chk("wrap frames_out", 32'(frames_out), 32'd1);
      chk("wrap rx_valid low", 32'(rx_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
